// File: rtl/mib_pkg.sv
// MIB register map, scheduler state encoding and bus-cycle helpers shared by
// the access scheduler and its arbiter.
package mib_pkg;

    localparam logic [3:0] REG_NOP  = 4'h0;
    localparam logic [3:0] REG_ADR0 = 4'h1;
    localparam logic [3:0] REG_ADR1 = 4'h2;
    localparam logic [3:0] REG_ADR2 = 4'h3;
    localparam logic [3:0] REG_WD0  = 4'h4;
    localparam logic [3:0] REG_WD1  = 4'h5;
    localparam logic [3:0] REG_RD0  = 4'h6;
    localparam logic [3:0] REG_RD1  = 4'h7;
    localparam logic [3:0] REG_MRD  = 4'h8;
    localparam logic [3:0] REG_MWR  = 4'h9;
    localparam logic [3:0] REG_STAT = 4'hA;

    localparam int RDY_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SA0,
        ST_SA1,
        ST_SA2,
        ST_SD0,
        ST_SD1,
        ST_STW,
        ST_STR,
        ST_GUARD,
        ST_POLL,
        ST_PCHK,
        ST_RLO,
        ST_RLOC,
        ST_RHI,
        ST_RHIC,
        ST_DONE
    } mib_state_e;

    typedef struct packed {
        logic       cs;
        logic       wr;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] din;
    } mib_bus_t;

    localparam mib_bus_t BUS_IDLE = '0;

    function automatic mib_bus_t bus_wr(input logic [3:0] addr, input logic [7:0] din);
        mib_bus_t b;
        b.cs   = 1'b1;
        b.wr   = 1'b1;
        b.rd   = 1'b0;
        b.addr = addr;
        b.din  = din;
        return b;
    endfunction

    function automatic mib_bus_t bus_rd(input logic [3:0] addr);
        mib_bus_t b;
        b.cs   = 1'b1;
        b.wr   = 1'b0;
        b.rd   = 1'b1;
        b.addr = addr;
        b.din  = 8'h00;
        return b;
    endfunction

endpackage

// File: rtl/mib_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant while enabled, pointer
// remembers who was served last and moves only when a grant is issued.
module mib_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_gnt_en,
    output logic [1:0] o_gnt
);

    // 1 = requester 1 served last, so requester 0 wins a tie
    logic r_last;

    always_comb begin
        o_gnt = 2'b00;
        if (i_gnt_en) begin
            if (i_req == 2'b11) begin
                o_gnt = r_last ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/mib_access_scheduler.sv
// Shares the MIB register port between two requesters and expands each 16-bit
// word access into the MIB load / start / poll / read-back register sequence.
module mib_access_scheduler
    import mib_pkg::*;
#(
    parameter int GUARD_CYCLES  = 3,
    parameter int TIMEOUT_POLLS = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [22:0] i_addr0,
    input  logic [22:0] i_addr1,
    input  logic [15:0] i_wdata0,
    input  logic [15:0] i_wdata1,
    output logic        o_done0,
    output logic        o_done1,
    output logic        o_err,
    output logic [15:0] o_rdata,
    output logic        o_busy,
    output logic        o_mib_cs,
    output logic        o_mib_wr,
    output logic        o_mib_rd,
    output logic [3:0]  o_mib_addr,
    output logic [7:0]  o_mib_din,
    input  logic [7:0]  i_mib_dout,
    output mib_state_e  o_dbg_state
);

    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);
    localparam logic [7:0] POLL_LIMIT = 8'(TIMEOUT_POLLS);

    mib_state_e  r_state;
    logic        r_id;
    logic        r_we;
    logic [22:0] r_addr;
    logic [15:0] r_wdata;
    logic [3:0]  r_guard_cnt;
    logic [7:0]  r_poll_cnt;
    mib_bus_t    r_bus;
    logic        r_busy;
    logic        r_done0;
    logic        r_done1;
    logic        r_err;
    logic [15:0] r_rdata;

    logic [1:0]  w_gnt;
    logic        w_gnt_en;
    logic [22:0] w_addr_sel;
    logic [7:0]  w_poll_inc;

    assign w_gnt_en   = (r_state == ST_IDLE);
    assign w_addr_sel = w_gnt[1] ? i_addr1 : i_addr0;
    assign w_poll_inc = (r_poll_cnt >= POLL_LIMIT) ? POLL_LIMIT : r_poll_cnt + 8'd1;

    mib_rr_arb2 u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    ({i_req1, i_req0}),
        .i_gnt_en (w_gnt_en),
        .o_gnt    (w_gnt)
    );

    // Bus outputs are loaded on the edge that enters a state, so each state's
    // register access is visible on the bus for exactly that state's cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_id        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_guard_cnt <= '0;
            r_poll_cnt  <= '0;
            r_bus       <= BUS_IDLE;
            r_busy      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_bus   <= BUS_IDLE;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_id        <= w_gnt[1];
                        r_we        <= w_gnt[1] ? i_we1 : i_we0;
                        r_addr      <= w_addr_sel;
                        r_wdata     <= w_gnt[1] ? i_wdata1 : i_wdata0;
                        r_guard_cnt <= '0;
                        r_poll_cnt  <= '0;
                        r_busy      <= 1'b1;
                        r_bus       <= bus_wr(REG_ADR0, w_addr_sel[7:0]);
                        r_state     <= ST_SA0;
                    end
                end
                ST_SA0: begin
                    r_bus   <= bus_wr(REG_ADR1, r_addr[15:8]);
                    r_state <= ST_SA1;
                end
                ST_SA1: begin
                    r_bus   <= bus_wr(REG_ADR2, {1'b0, r_addr[22:16]});
                    r_state <= ST_SA2;
                end
                ST_SA2: begin
                    if (r_we) begin
                        r_bus   <= bus_wr(REG_WD0, r_wdata[7:0]);
                        r_state <= ST_SD0;
                    end else begin
                        r_bus   <= bus_wr(REG_MRD, 8'h00);
                        r_state <= ST_STR;
                    end
                end
                ST_SD0: begin
                    r_bus   <= bus_wr(REG_WD1, r_wdata[15:8]);
                    r_state <= ST_SD1;
                end
                ST_SD1: begin
                    r_bus   <= bus_wr(REG_MWR, 8'h00);
                    r_state <= ST_STW;
                end
                ST_STW, ST_STR: begin
                    r_state <= ST_GUARD;
                end
                // The status register lags the start strobe; polling early
                // could read a stale RDY left over from the previous command.
                ST_GUARD: begin
                    if (r_guard_cnt == GUARD_LAST) begin
                        r_bus   <= bus_rd(REG_STAT);
                        r_state <= ST_POLL;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + 4'd1;
                    end
                end
                ST_POLL: begin
                    r_state <= ST_PCHK;
                end
                ST_PCHK: begin
                    if (i_mib_dout[RDY_BIT]) begin
                        if (r_we) begin
                            r_done0 <= ~r_id;
                            r_done1 <= r_id;
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_bus   <= bus_rd(REG_RD0);
                            r_state <= ST_RLO;
                        end
                    end else begin
                        r_poll_cnt <= w_poll_inc;
                        if (w_poll_inc == POLL_LIMIT) begin
                            r_done0 <= ~r_id;
                            r_done1 <= r_id;
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end else begin
                            r_bus   <= bus_rd(REG_STAT);
                            r_state <= ST_POLL;
                        end
                    end
                end
                ST_RLO: begin
                    r_state <= ST_RLOC;
                end
                ST_RLOC: begin
                    r_rdata[7:0] <= i_mib_dout;
                    r_bus        <= bus_rd(REG_RD1);
                    r_state      <= ST_RHI;
                end
                ST_RHI: begin
                    r_state <= ST_RHIC;
                end
                ST_RHIC: begin
                    r_rdata[15:8] <= i_mib_dout;
                    r_done0       <= ~r_id;
                    r_done1       <= r_id;
                    r_busy        <= 1'b0;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_done0     = r_done0;
    assign o_done1     = r_done1;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_busy      = r_busy;
    assign o_mib_cs    = r_bus.cs;
    assign o_mib_wr    = r_bus.wr;
    assign o_mib_rd    = r_bus.rd;
    assign o_mib_addr  = r_bus.addr;
    assign o_mib_din   = r_bus.din;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mib_access_scheduler.sv
// Directed bench for mib_access_scheduler with a behavioural MIB register
// model (1-cycle read latency, programmable RDY timing).
module tb_mib_access_scheduler;
  import mib_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req0 = 1'b0, i_req1 = 1'b0;
  logic        i_we0 = 1'b0, i_we1 = 1'b0;
  logic [22:0] i_addr0 = '0, i_addr1 = '0;
  logic [15:0] i_wdata0 = '0, i_wdata1 = '0;
  logic [7:0]  i_mib_dout = '0;
  logic        o_done0, o_done1, o_err, o_busy;
  logic        o_mib_cs, o_mib_wr, o_mib_rd;
  logic [15:0] o_rdata;
  logic [3:0]  o_mib_addr;
  logic [7:0]  o_mib_din;
  mib_state_e  o_dbg_state;

  always #10 clk = ~clk;

  mib_access_scheduler dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_done0(o_done0), .o_done1(o_done1), .o_err(o_err), .o_rdata(o_rdata), .o_busy(o_busy),
    .o_mib_cs(o_mib_cs), .o_mib_wr(o_mib_wr), .o_mib_rd(o_mib_rd),
    .o_mib_addr(o_mib_addr), .o_mib_din(o_mib_din), .i_mib_dout(i_mib_dout),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] wr_log[$];
  logic [11:0] exp_q[$];
  logic [3:0]  rd_log[$];
  logic [17:0] done_log[$];   // {err, id, rdata}
  int          done_cyc[$];
  int          busy_rise[$];
  int          cyc = 0;
  int          polls = 0;
  int          first_poll_cyc = -1;
  int          strobe_cyc = 0;
  int          proto_err = 0;
  logic        busy_q = 1'b0;

  // MIB model knobs
  int          sc = 1000;
  int          mdl_delay = 4;
  logic        mdl_stuck = 1'b0;
  logic        mdl_stale = 1'b0;
  logic [15:0] mdl_rval = 16'h0000;
  logic [7:0]  pend_dout = 8'h00;
  logic        mdl_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- MIB model and bus monitor ----------------
  // Bus is observed mid-cycle; the read response lands on the next rising
  // edge so the DUT sees it one cycle after its rd strobe.
  always @(negedge clk) begin
    cyc++;
    if (o_mib_cs && o_mib_wr && (o_mib_addr == REG_MRD || o_mib_addr == REG_MWR)) begin
      sc = 0;
      strobe_cyc = cyc;
    end else if (sc < 1000) begin
      sc++;
    end
    mdl_rdy = !mdl_stuck && ((sc >= mdl_delay) || (mdl_stale && sc <= 2));
    if (o_mib_cs && o_mib_wr) wr_log.push_back({o_mib_addr, o_mib_din});
    if (o_mib_cs && o_mib_rd) begin
      if (o_mib_addr == REG_STAT) begin
        polls++;
        if (first_poll_cyc < 0) first_poll_cyc = cyc;
        pend_dout = {7'b0, mdl_rdy};
      end else begin
        rd_log.push_back(o_mib_addr);
        if (o_mib_addr == REG_RD0) pend_dout = mdl_rval[7:0];
        else if (o_mib_addr == REG_RD1) pend_dout = mdl_rval[15:8];
        else pend_dout = 8'h00;
      end
    end
    if (((o_mib_wr || o_mib_rd) && !o_mib_cs) || (o_mib_wr && o_mib_rd)) proto_err++;
    if (o_done0 && o_done1) proto_err++;
    if (o_busy && !busy_q) busy_rise.push_back(cyc);
    busy_q = o_busy;
    if (o_done0 || o_done1) begin
      done_log.push_back({o_err, o_done1, o_rdata});
      done_cyc.push_back(cyc);
    end
  end

  always @(posedge clk) i_mib_dout <= pend_dout;

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); done_log.delete();
    done_cyc.delete(); busy_rise.delete();
    polls = 0; first_poll_cyc = -1;
  endtask

  task automatic wait_dones(input string tag, input int n, input int budget, input logic drop);
    int cnt = 0;
    for (int k = 0; k < budget && cnt < n; k++) begin
      @(negedge clk);
      if (o_done0) begin cnt++; if (drop) i_req0 = 1'b0; end
      if (o_done1) begin cnt++; if (drop) i_req1 = 1'b0; end
    end
    check_eq(tag, cnt, n);
    #1;
  endtask

  task automatic check_wr(input string tag);
    check_eq({tag, "_wr_count"}, wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      check_eq($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_q[i]);
  endtask

  task automatic check_done(input string tag, input int k, input logic id,
                            input logic err, input logic [15:0] rdata);
    check_eq({tag, "_done_id"}, done_log[k][16], id);
    check_eq({tag, "_done_err"}, done_log[k][17], err);
    check_eq({tag, "_done_rdata"}, done_log[k][15:0], rdata);
  endtask

  task automatic pulse_reset();
    @(negedge clk); i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  logic seen;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_bus", {o_mib_cs, o_mib_wr, o_mib_rd, o_mib_addr, o_mib_din}, 0);
    check_eq("rst_status", {o_done0, o_done1, o_err, o_busy, o_rdata}, 0);
    check_eq("rst_state", o_dbg_state, ST_IDLE);
    @(negedge clk); i_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write from requester 0, RDY on the first poll
    clear_logs(); mdl_delay = 4;
    i_we0 = 1'b1; i_addr0 = 23'h12345; i_wdata0 = 16'hBEEF; i_req0 = 1'b1;
    wait_dones("wr_wait", 1, 200, 1'b1);
    exp_q = '{12'h145, 12'h223, 12'h301, 12'h4EF, 12'h5BE, 12'h900};
    check_wr("wr");
    check_eq("wr_polls", polls, 1);
    check_eq("wr_guard_gap", first_poll_cyc - strobe_cyc, 4);
    check_done("wr", 0, 1'b0, 1'b0, 16'h0000);
    check_eq("wr_latency", done_cyc[0] - busy_rise[0] + 1, 12);

    // Single read from requester 1
    repeat (2) @(negedge clk);
    clear_logs(); mdl_rval = 16'hA55A;
    i_we1 = 1'b0; i_addr1 = 23'h7FFFFF; i_req1 = 1'b1;
    wait_dones("rd_wait", 1, 200, 1'b1);
    exp_q = '{12'h1FF, 12'h2FF, 12'h37F, 12'h800};
    check_wr("rd");
    check_eq("rd_rdlog_n", rd_log.size(), 2);
    check_eq("rd_rdlog", {rd_log[0], rd_log[1]}, 8'h67);
    check_done("rd", 0, 1'b1, 1'b0, 16'hA55A);
    check_eq("rd_latency", done_cyc[0] - busy_rise[0] + 1, 14);
    repeat (3) @(negedge clk);
    check_eq("rd_rdata_held", o_rdata, 16'hA55A);

    // Timeout: RDY never rises, read must leave rdata untouched
    clear_logs(); mdl_stuck = 1'b1; mdl_rval = 16'h1111;
    i_we0 = 1'b0; i_addr0 = 23'h000001; i_req0 = 1'b1;
    wait_dones("tmo_wait", 1, 400, 1'b1);
    check_eq("tmo_polls", polls, 64);
    check_done("tmo", 0, 1'b0, 1'b1, 16'hA55A);
    check_eq("tmo_latency", done_cyc[0] - busy_rise[0] + 1, 136);
    check_eq("tmo_rdlog_n", rd_log.size(), 0);
    @(negedge clk);
    check_eq("tmo_err_pulse", o_err, 1'b0);
    mdl_stuck = 1'b0;

    // Stale RDY: high through the strobe, drops, then real RDY 8 cycles later
    repeat (2) @(negedge clk);
    clear_logs(); mdl_stale = 1'b1; mdl_delay = 8;
    i_we1 = 1'b1; i_addr1 = 23'h000ABC; i_wdata1 = 16'h1234; i_req1 = 1'b1;
    wait_dones("stale_wait", 1, 200, 1'b1);
    check_eq("stale_guard_gap", first_poll_cyc - strobe_cyc, 4);
    check_eq("stale_polls", polls, 3);
    check_done("stale", 0, 1'b1, 1'b0, 16'hA55A);
    check_eq("stale_latency", done_cyc[0] - busy_rise[0] + 1, 16);
    mdl_stale = 1'b0; mdl_delay = 4;

    // Contention straight out of reset
    pulse_reset();
    clear_logs();
    i_we0 = 1'b1; i_addr0 = 23'h000100; i_wdata0 = 16'h0F0F;
    i_we1 = 1'b1; i_addr1 = 23'h000200; i_wdata1 = 16'hF0F0;
    i_req0 = 1'b1; i_req1 = 1'b1;
    wait_dones("cont_wait", 2, 200, 1'b1);
    check_eq("cont_first_id", done_log[0][16], 1'b0);
    check_eq("cont_second_id", done_log[1][16], 1'b1);
    check_eq("cont_regrant_gap", busy_rise[1] - done_cyc[0], 2);

    // Both held high: grants alternate
    clear_logs();
    i_req0 = 1'b1; i_req1 = 1'b1;
    wait_dones("alt_wait", 4, 300, 1'b0);
    i_req0 = 1'b0; i_req1 = 1'b0;
    check_eq("alt_order", {done_log[0][16], done_log[1][16], done_log[2][16], done_log[3][16]}, 4'b0101);

    // Asynchronous reset while the FSM sits in PCHK
    repeat (3) @(negedge clk);
    clear_logs(); mdl_stuck = 1'b1;
    i_we0 = 1'b0; i_addr0 = 23'h000010; i_req0 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (o_mib_cs && o_mib_rd && o_mib_addr == REG_STAT) seen = 1'b1;
    end
    check_eq("arst_poll_seen", seen, 1'b1);
    i_we1 = 1'b1; i_addr1 = 23'h000020; i_req1 = 1'b1;
    @(posedge clk); #3;
    check_eq("arst_in_pchk", o_dbg_state, ST_PCHK);
    i_rst_n = 1'b0; #1;
    check_eq("arst_bus", {o_mib_cs, o_mib_wr, o_mib_rd, o_mib_addr, o_mib_din}, 0);
    check_eq("arst_busy", o_busy, 1'b0);
    check_eq("arst_state", o_dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);
    check_eq("arst_no_done", done_log.size(), 0);
    mdl_stuck = 1'b0;
    i_rst_n = 1'b1;
    wait_dones("arst_wait0", 1, 200, 1'b1);
    check_eq("arst_first_id", done_log[0][16], 1'b0);
    wait_dones("arst_wait1", 1, 200, 1'b1);
    check_eq("arst_second_id", done_log[1][16], 1'b1);

    check_eq("bus_protocol", proto_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mib_access_scheduler.md
Name: mib_access_scheduler

Overview:
- Bus master that shares the memory interface block (MIB) register port between two requesters, e.g. the UART RX store path and the TX fetch path.
- Arbitrates round-robin.
- Turns a 16-bit word read/write at a 23-bit word address into the MIB register-access sequence: load address/data registers, start strobe, status poll, read-back.
- Returns a one-cycle done pulse with read data or an error flag.

Parameters:
- GUARD_CYCLES, 3, idle cycles after a start strobe before the first status poll; covers MIB status-register lag. Legal range 1..15.
- TIMEOUT_POLLS, 64, maximum RDY polls before the operation is aborted with err; 8-bit counter.

Ports:
- Clock  in  1  system clock, 50 MHz
- Resetb  in  1  asynchronous, active-low reset
- req0 / req1  in  1  request; held high until the matching done pulse
- we0 / we1  in  1  1 = write, 0 = read; sampled at grant
- addr0 / addr1  in  23  word address; sampled at grant
- wdata0 / wdata1  in  16  write data; sampled at grant
- done0 / done1  out  1  one-cycle completion pulse
- err  out  1  valid with done: operation timed out
- rdata  out  16  read data; valid with done of a read, held until next done
- busy  out  1  high from grant until the done cycle
- mib_cs  out  1  MIB ChipSelect
- mib_wr  out  1  MIB Write strobe
- mib_rd  out  1  MIB Read strobe
- mib_addr  out  4  MIB register select
- mib_din  out  8  MIB DataIn
- mib_dout  in  8  MIB DataOut

Behaviour:
- Reset: all outputs 0; FSM in IDLE; RR pointer favours requester 0. Assertion mid-operation aborts immediately. No done is issued, and bus strobes drop asynchronously.
- Bus rules:
  - At most one of mib_wr/mib_rd high, and only with mib_cs=1.
  - All bus outputs are registered.
  - Read data is sampled from mib_dout in the cycle after the rd cycle (1-cycle latency).
- Arbitration, in IDLE only:
  - Only one request: grant it.
  - Both requesting: grant the one not served last.
  - The pointer updates at grant.
  - On grant, capture we/addr/wdata and the requester id, then go to SA0.
  - Requests arriving while busy wait; there is no preemption.
- Write sequence, one cycle each, mib_wr=1:
  - SA0: addr 1, din = addr[7:0]
  - SA1: addr 2, din = addr[15:8]
  - SA2: addr 3, din = {1'b0, addr[22:16]}
  - SD0: addr 4, din = wdata[7:0]
  - SD1: addr 5, din = wdata[15:8]
  - STW: addr 9
- Read sequence:
  - SA0, SA1, SA2 as above, then STR: addr 8, mib_wr=1.
- After the start strobe:
  - GUARD: bus idle for GUARD_CYCLES.
  - POLL: addr A, mib_rd=1.
  - PCHK: test mib_dout[0]. If 1, proceed. If 0, increment the poll counter and return to POLL. When the counter reaches TIMEOUT_POLLS, go to DONE with err=1 and rdata unchanged.
- Read completion:
  - RLO: addr 6, rd.
  - RLOC: rdata[7:0] <= mib_dout.
  - RHI: addr 7, rd.
  - RHIC: rdata[15:8] <= mib_dout.
  - Then DONE.
- DONE: pulse done of the captured requester (and err if set); busy=0; return to IDLE. A new grant is possible the following cycle.
- Latency, grant cycle to done with RDY on the first poll:
  - write = 6 + GUARD + 2 + 1 = 12 cycles at defaults
  - read = 4 + GUARD + 2 + 4 + 1 = 14 cycles at defaults
- Counters: the guard and poll counters clear at each grant and do not wrap; the poll counter saturates at TIMEOUT_POLLS.
- A request dropped before its done is protocol misuse. The operation still completes and the done pulse is still issued.

Decomposition:
- Package mib_pkg:
  - MIB register-select constants: NOP=0, ADR0=1, ADR1=2, ADR2=3, WD0=4, WD1=5, RD0=6, RD1=7, MRD=8, MWR=9, STAT=A
  - FSM state enumeration
  - RDY bit index = 0
- Sub-module mib_rr_arb2: two-request round-robin arbiter with a pointer register, grant-enable input and one-hot grant output.

Test Plan:
- Single write: req0, we0=1, addr0=23'h12345, wdata0=16'hBEEF; MIB model RDY=1 after 4 cycles -> bus sequence (1,45),(2,23),(3,01),(4,EF),(5,BE),(9,-), guard, polls until RDY, then done0 with err=0.
- Single read: req1, addr1=23'h7FFFFF, model returns 16'hA55A -> address bytes FF,FF,7F; start on addr 8; reads addr 6 then 7; done1 with rdata=16'hA55A.
- Contention: req0 and req1 both asserted in the same cycle from reset -> req0 served first, req1 granted the cycle after done0; hold both asserted -> grants alternate 0,1,0,1.
- Timeout: RDY stuck 0 -> exactly 64 polls, then done with err=1 and rdata unchanged.
- Async reset mid-poll: assert Resetb=0 in PCHK -> all mib_* outputs 0 immediately, no done; after release, req0 with both requests pending is granted first.
- Stale status: RDY=1 held through the start strobe and dropping 2 cycles later -> no poll is issued inside the guard window, so the first valid RDY is not mistaken.
